// File: rtl/wave_xfade_mux.sv
// N-channel sample selector with a linear crossfade on selection changes.
// Optional macro WAVE_XFADE_MUX_XFADE_EN builds the crossfade; without it, channel changes are hard switches.
module wave_xfade_mux #(
  parameter int DATA_W    = 16,
  parameter int N_CH      = 4,
  parameter int SEL_W     = 2,
  parameter int FADE_LOG2 = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sample_en,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic [SEL_W-1:0]         o_cur_sel
);

  if ((1 << SEL_W) < N_CH || N_CH < 2 || FADE_LOG2 < 1 || FADE_LOG2 > 10) begin : g_param_check
    $error("wave_xfade_mux: illegal parameter combination");
  end

  logic signed [DATA_W-1:0] ch [N_CH];
  logic [SEL_W-1:0]         eff;
  logic [SEL_W-1:0]         cur_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign ch[c] = i_data[c*DATA_W +: DATA_W];
  end

  // Out-of-range selects fold onto the last real channel.
  always_comb begin
    if (32'(i_sel) < N_CH) eff = i_sel;
    else                   eff = SEL_W'(N_CH - 1);
  end

  assign o_cur_sel = cur_q;

`ifdef WAVE_XFADE_MUX_XFADE_EN

  localparam int M  = 1 << FADE_LOG2;
  localparam int PW = DATA_W + FADE_LOG2 + 2;

  typedef enum logic {IDLE, FADE} state_t;

  state_t                   state_q, state_d;
  logic [FADE_LOG2-1:0]     k_q, k_d;
  logic [SEL_W-1:0]         tgt_q, tgt_d, cur_d;
  logic signed [DATA_W-1:0] data_d;
  logic signed [PW-1:0]     cur_ext, tgt_ext, w_old, w_new, mix_sum, mix_shift;
  logic                     last_step;

  assign last_step = (k_q == FADE_LOG2'(M - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      tgt_q   <= '0;
      cur_q   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= i_sample_en;
      if (i_sample_en) begin
        state_q <= state_d;
        k_q     <= k_d;
        tgt_q   <= tgt_d;
        cur_q   <= cur_d;
        o_data  <= data_d;
        o_busy  <= (state_d == FADE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eff != cur_q) state_d = FADE;
      FADE:    if (last_step)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Weights sum to M, so the shifted result is a convex blend and always fits DATA_W.
  always_comb begin
    cur_ext   = PW'(ch[cur_q]);
    tgt_ext   = PW'(ch[tgt_q]);
    w_old     = PW'(M) - PW'(k_q);
    w_new     = PW'(k_q);
    mix_sum   = cur_ext * w_old + tgt_ext * w_new;
    mix_shift = mix_sum >>> FADE_LOG2;

    k_d    = k_q;
    tgt_d  = tgt_q;
    cur_d  = cur_q;
    data_d = ch[cur_q];
    case (state_q)
      IDLE: begin
        if (eff != cur_q) begin
          tgt_d = eff;
          k_d   = FADE_LOG2'(1);
        end
      end
      FADE: begin
        data_d = mix_shift[DATA_W-1:0];
        k_d    = k_q + FADE_LOG2'(1);
        if (last_step) cur_d = tgt_q;
      end
      default: ;
    endcase
  end

`else

  // Hard switch: the new channel is committed and emitted on the same strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cur_q   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_sample_en;
      if (i_sample_en) begin
        cur_q  <= eff;
        o_data <= ch[eff];
      end
    end
  end

  assign o_busy = 1'b0;

`endif

endmodule

// File: tb/tb_wave_xfade_mux.sv
// Directed bench for wave_xfade_mux; covers the crossfade when WAVE_XFADE_MUX_XFADE_EN is defined.
module tb_wave_xfade_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [1:0]  sel = '0;
  logic signed [15:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
  logic signed [15:0] b0 = '0, b1 = '0, b2 = '0;
  logic signed [15:0] o_data, b_data;
  logic        o_valid, o_busy, b_valid, b_busy;
  logic [1:0]  o_cur_sel, b_cur_sel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wave_xfade_mux dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_en(sample_en), .i_sel(sel),
    .i_data({ch3, ch2, ch1, ch0}),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_cur_sel(o_cur_sel)
  );

  // Three-channel instance exercising the out-of-range select fold.
  wave_xfade_mux #(.N_CH(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_en(sample_en), .i_sel(sel),
    .i_data({b2, b1, b0}),
    .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy), .o_cur_sel(b_cur_sel)
  );

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the following negedge, half a cycle after the update.
  task automatic apply_stimulus;
    @(negedge clk) sample_en = 1'b1;
    @(negedge clk) sample_en = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    #2;
    check_output("rst_data",  $signed(o_data), 0);
    check_output("rst_valid", o_valid, 0);
    check_output("rst_busy",  o_busy, 0);
    check_output("rst_cur",   o_cur_sel, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ch0 = 16'sd1000; ch1 = -16'sd1000; ch2 = 16'sd1234; ch3 = -16'sd7;
    b0 = 16'sd11; b1 = 16'sd22; b2 = 16'sd33;

    sel = 2'd0;
    apply_stimulus();
    check_output("idle_data",  $signed(o_data), 1000);
    check_output("idle_valid", o_valid, 1);
    check_output("idle_busy",  o_busy, 0);
    @(negedge clk);
    check_output("valid_pulse", o_valid, 0);
    check_output("hold_data",  $signed(o_data), 1000);

    sel = 2'd1;
    repeat (3) @(negedge clk);
    check_output("nostrobe_cur",  o_cur_sel, 0);
    check_output("nostrobe_data", $signed(o_data), 1000);

`ifdef WAVE_XFADE_MUX_XFADE_EN
    apply_stimulus();
    check_output("detect_data", $signed(o_data), 1000);
    check_output("detect_busy", o_busy, 1);
    check_output("detect_cur",  o_cur_sel, 0);
    for (int k = 1; k < 64; k++) begin
      if (k == 10) sel = 2'd3;
      apply_stimulus();
      case (k)
        1:  check_output("mix_k1",  $signed(o_data), 968);
        16: check_output("mix_k16", $signed(o_data), 500);
        32: check_output("mix_k32", $signed(o_data), 0);
        48: check_output("mix_k48", $signed(o_data), -500);
        63: check_output("mix_k63", $signed(o_data), -969);
        default: ;
      endcase
      if (k == 20) begin
        check_output("midfade_cur",  o_cur_sel, 0);
        check_output("midfade_busy", o_busy, 1);
      end
    end
    check_output("end_cur",  o_cur_sel, 1);
    check_output("end_busy", o_busy, 0);
    ch3 = 16'sd0;
    apply_stimulus();
    check_output("refade_data", $signed(o_data), -1000);
    check_output("refade_busy", o_busy, 1);
    apply_stimulus();
    check_output("refade_k1",   $signed(o_data), -985);
    check_output("refade_cur",  o_cur_sel, 1);
`else
    apply_stimulus();
    check_output("hard_data", $signed(o_data), -1000);
    check_output("hard_cur",  o_cur_sel, 1);
    check_output("hard_busy", o_busy, 0);

    sel = 2'd2;
    apply_stimulus();
    check_output("static_data", $signed(o_data), 1234);
    check_output("static_cur",  o_cur_sel, 2);
    check_output("fold_same_data", $signed(b_data), 33);
    ch2 = 16'sd555;
    apply_stimulus();
    check_output("reread_data", $signed(o_data), 555);

    sel = 2'd3;
    apply_stimulus();
    check_output("sel3_data",  $signed(o_data), -7);
    check_output("sel3_cur",   o_cur_sel, 3);
    check_output("fold_data",  $signed(b_data), 33);
    check_output("fold_cur",   b_cur_sel, 2);
    check_output("fold_busy",  b_busy, 0);
    check_output("fold_valid", b_valid, 1);
`endif

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_data",  $signed(o_data), 0);
    check_output("arst_valid", o_valid, 0);
    check_output("arst_busy",  o_busy, 0);
    check_output("arst_cur",   o_cur_sel, 0);
    check_output("arst_b_cur", b_cur_sel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_xfade_mux.md
Name: wave_xfade_mux

Overview:
Parametrised N-channel waveform selector, successor to the fixed 4-way oscillator mux. Registers one selected channel per sample strobe. On a selection change, it crossfades linearly from the old channel to the new one over 2^FADE_LOG2 sample strobes, so there are no step discontinuities (clicks). Sits between the oscillator bank (sine/square/tri/noise and future sources) and the output mixer/DAC path.

Parameters:
DATA_W, 16, sample width; signed two's complement
N_CH, 4, number of input channels (2..16)
SEL_W, 2, select width; must satisfy 2^SEL_W >= N_CH
FADE_LOG2, 6, crossfade length exponent; M = 2^FADE_LOG2 (range 1..10)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_sample_en  in  1  one-cycle sample strobe; all state advances only on cycles where it is high
i_sel  in  SEL_W  requested channel
i_data  in  N_CH*DATA_W  packed channel samples; channel c occupies bits [c*DATA_W +: DATA_W]
o_data  out  DATA_W  registered output sample
o_valid  out  1  high for exactly one cycle, the cycle after each i_sample_en
o_busy  out  1  high while the FADE state is active
o_cur_sel  out  SEL_W  channel currently committed as the source

Behaviour:
- Reset (async assert, sync release): o_data=0, o_valid=0, o_busy=0, o_cur_sel=0, state=IDLE, k=0, tgt=0.
- Effective select: eff = i_sel if i_sel < N_CH, else N_CH-1 (out-of-range maps to the last channel).
- Latency: o_data/o_valid update on the clock edge at which i_sample_en is high. Output appears one cycle after the strobe. o_data holds between strobes.
- States: IDLE, FADE. k is a FADE_LOG2-bit step counter.
- IDLE, on strobe: o_data <= ch[cur]. If eff != cur, then tgt <= eff, k <= 1, go to FADE.
- FADE, on strobe: o_data <= mix(k), k <= k+1. If k == M-1, then cur <= tgt and go to IDLE.
- Fade output: the detect strobe outputs the old channel pure, then M-1 mixed samples follow, then the new channel pure.
- mix(k) = (ch[cur]*(M-k) + ch[tgt]*k) >>> FADE_LOG2. Arithmetic shift gives floor rounding. Products are signed at DATA_W+FADE_LOG2+2 bits. The result always fits DATA_W (convex combination), so no saturation is needed.
- Channel samples are re-read on every strobe; both channels may change freely during a fade.
- i_sel changes during FADE are ignored. On return to IDLE, the next strobe compares eff against the new cur and starts a fresh fade if they differ.
- Sel returning to the original channel mid-fade: the fade completes to tgt, then a new fade back begins.
- No strobe: no state change, regardless of i_sel.
- Reset mid-fade: immediate return to reset values; no partial commit.
- o_busy = (state == FADE), registered.
- o_cur_sel changes only at the FADE→IDLE transition.

Optional Feature:
WAVE_XFADE_MUX_XFADE_EN
- Defined: crossfade behaviour as above.
- Undefined:
  - The FADE state, counter and multipliers are not built.
  - On a strobe with eff != cur: cur <= eff, and o_data <= ch[eff] at that same strobe (hard switch).
  - o_busy is tied to 0.
  - Latency is unchanged.

Test Plan:
(All with defaults; M = 64.)
- Reset: assert i_rst_n=0 mid-stream -> o_data=0, o_valid=0, o_busy=0, o_cur_sel=0 without waiting for a clock edge.
- Static select: sel=2, ch2=16'sd1234, strobe every 4 clocks -> o_data=1234 one cycle after each strobe; o_valid is a one-cycle pulse; o_busy=0.
- Crossfade 0→1: ch0=1000, ch1=-1000, sel 0→1.
  - Detect strobe -> 1000; k=1 -> 968; k=16 -> 500; k=32 -> 0; k=48 -> -500; k=63 -> -969.
  - Next strobe -> -1000, o_cur_sel=1, o_busy falls.
- Sel changes mid-fade (1 at k=10, then 3): fade to 1 completes untouched; the following strobe starts a fade 1→3.
- Out-of-range select: N_CH=3, SEL_W=2, sel=3 -> behaves exactly as sel=2 (fade target 2, o_cur_sel=2).
- Macro undefined: sel 0→1 with ch0=1000, ch1=-1000 -> the output jumps from 1000 to -1000 at the first strobe after the change; o_busy stays 0.
